// File: rtl/ascii_raster_writer_if.sv
// Stream bundle for ascii_raster_writer: shaded tile input channel and raster
// pixel output channel, both valid/ready handshakes.
// The master side drives tiles and accepts pixels; the slave side is the writer.
interface ascii_raster_writer_if #(
  parameter int TILE_WIDTH  = 8,
  parameter int TILE_HEIGHT = 8,
  parameter int DATA_WIDTH  = 24
);

  logic [TILE_WIDTH-1:0][TILE_HEIGHT-1:0] tile_in;
  logic                                   tile_valid;
  logic                                   tile_ready;

  logic [DATA_WIDTH-1:0]                  pixel_out;
  logic                                   pixel_valid;
  logic                                   pixel_ready;
  logic                                   pixel_sol;
  logic                                   pixel_eol;
  logic                                   pixel_sof;
  logic                                   pixel_eof;

  modport master (
    output tile_in,
    output tile_valid,
    input  tile_ready,
    input  pixel_out,
    input  pixel_valid,
    output pixel_ready,
    input  pixel_sol,
    input  pixel_eol,
    input  pixel_sof,
    input  pixel_eof
  );

  modport slave (
    input  tile_in,
    input  tile_valid,
    output tile_ready,
    output pixel_out,
    output pixel_valid,
    input  pixel_ready,
    output pixel_sol,
    output pixel_eol,
    output pixel_sof,
    output pixel_eof
  );

endinterface

// File: rtl/ascii_raster_writer.sv
// ascii_raster_writer: collects one row of shaded tile bitmasks, then replays
// that row as a left-to-right, top-to-bottom pixel stream, painting set bits
// with FG_COLOR and clear bits with BG_COLOR. Scanline and frame markers are
// carried alongside every pixel.
//
// Optional build macro ASCII_RASTER_DBUF_EN: two ping-pong row banks so the
// next row can be filled while the current one drains. Without it a single
// bank is used and tile input is closed for the whole drain phase.
module ascii_raster_writer #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int TILE_WIDTH  = 8,
  parameter int TILE_HEIGHT = 8,
  parameter int COLORS      = 3,
  parameter int COLOR_DEPTH = 8,
  parameter int DATA_WIDTH  = COLORS * COLOR_DEPTH,
  parameter logic [DATA_WIDTH-1:0] FG_COLOR = {DATA_WIDTH{1'b1}},
  parameter logic [DATA_WIDTH-1:0] BG_COLOR = {DATA_WIDTH{1'b0}}
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  ascii_raster_writer_if.slave io_rw
);

  localparam int TILES_X = WIDTH / TILE_WIDTH;
  localparam int TILES_Y = HEIGHT / TILE_HEIGHT;
  localparam int PXW     = (WIDTH > 1)       ? $clog2(WIDTH)       : 1;
  localparam int LYW     = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
  localparam int COLW    = (TILE_WIDTH > 1)  ? $clog2(TILE_WIDTH)  : 1;
  localparam int TXW     = (TILES_X > 1)     ? $clog2(TILES_X)     : 1;
  localparam int TYW     = (TILES_Y > 1)     ? $clog2(TILES_Y)     : 1;

  // ST_FILL: no row is being drained (waiting for a complete row).
  // ST_DRAIN: the buffered row is being walked out as pixels.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  logic [TXW-1:0]      r_fillTx;
  logic [PXW-1:0]      r_px;
  logic [LYW-1:0]      r_ly;
  logic [TYW-1:0]      r_ty;

  logic [DATA_WIDTH-1:0] r_pixelOut;
  logic                  r_pixelValid;
  logic                  r_pixelSol;
  logic                  r_pixelEol;
  logic                  r_pixelSof;
  logic                  r_pixelEof;

  logic           w_tileAcc;
  logic           w_fillLast;
  logic           w_draining;
  logic           w_load;
  logic           w_lastPx;
  logic           w_lastLy;
  logic           w_lastTy;
  logic           w_lastLoad;
  logic [TXW-1:0] w_tileSel;
  logic [COLW-1:0] w_col;
  logic           w_pixBit;

  assign w_fillLast = (r_fillTx == TXW'(TILES_X - 1));
  assign w_draining = (r_state == ST_DRAIN);
  assign w_load     = w_draining && (!r_pixelValid || io_rw.pixel_ready);
  assign w_lastPx   = (r_px == PXW'(WIDTH - 1));
  assign w_lastLy   = (r_ly == LYW'(TILE_HEIGHT - 1));
  assign w_lastTy   = (r_ty == TYW'(TILES_Y - 1));
  assign w_lastLoad = w_load && w_lastPx && w_lastLy;

  // Split the horizontal pixel position into tile column and x within tile.
  assign w_tileSel  = TXW'(32'(r_px) / TILE_WIDTH);
  assign w_col      = COLW'(32'(r_px) % TILE_WIDTH);

`ifdef ASCII_RASTER_DBUF_EN

  logic [TILE_WIDTH-1:0][TILE_HEIGHT-1:0] r_buf [2][TILES_X];
  logic r_fillBank;
  logic r_drainBank;
  logic r_fillFull;
  logic w_fillDone;
  logic w_swap;

  // The fill bank accepts tiles until it holds a complete row.
  assign w_tileAcc = io_rw.tile_valid && !r_fillFull;
  assign w_fillDone = r_fillFull || (w_tileAcc && w_fillLast);
  // Hand over a complete row either when nothing is draining or exactly when
  // the drain side loads its final pixel, so rows run back to back.
  assign w_swap    = w_fillDone && (!w_draining || w_lastLoad);

  assign io_rw.tile_ready = !r_fillFull;
  assign w_pixBit = r_buf[r_drainBank][w_tileSel][w_col][r_ly];

  // Write accepted tiles into the bank currently being filled.
  always_ff @(posedge i_clk) begin
    if (w_tileAcc) begin
      r_buf[r_fillBank][r_fillTx] <= io_rw.tile_in;
    end
  end

  // Bank bookkeeping: fill position, fill-complete flag and ping-pong swap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_FILL;
      r_fillTx    <= '0;
      r_fillBank  <= 1'b0;
      r_drainBank <= 1'b0;
      r_fillFull  <= 1'b0;
    end else begin
      if (w_tileAcc) begin
        r_fillTx <= w_fillLast ? '0 : r_fillTx + TXW'(1);
      end
      if (w_swap) begin
        r_state     <= ST_DRAIN;
        r_drainBank <= r_fillBank;
        r_fillBank  <= ~r_fillBank;
        r_fillFull  <= 1'b0;
      end else begin
        if (w_lastLoad) begin
          r_state <= ST_FILL;
        end
        if (w_tileAcc && w_fillLast) begin
          r_fillFull <= 1'b1;
        end
      end
    end
  end

`else

  logic [TILE_WIDTH-1:0][TILE_HEIGHT-1:0] r_buf [TILES_X];
  logic r_tileReady;

  assign w_tileAcc = io_rw.tile_valid && r_tileReady;
  assign io_rw.tile_ready = r_tileReady;
  assign w_pixBit = r_buf[w_tileSel][w_col][r_ly];

  // Write accepted tiles into the single row buffer.
  always_ff @(posedge i_clk) begin
    if (w_tileAcc) begin
      r_buf[r_fillTx] <= io_rw.tile_in;
    end
  end

  // Fill/drain sequencing; tile input is closed from the last tile of a row
  // until the last pixel of that row has been loaded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_FILL;
      r_fillTx    <= '0;
      r_tileReady <= 1'b1;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_tileAcc) begin
            if (w_fillLast) begin
              r_fillTx    <= '0;
              r_state     <= ST_DRAIN;
              r_tileReady <= 1'b0;
            end else begin
              r_fillTx <= r_fillTx + TXW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_lastLoad) begin
            r_state     <= ST_FILL;
            r_tileReady <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

`endif

  // Raster position: advances only when a pixel is loaded into the output
  // register; the tile-row index steps once per completed row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_px <= '0;
      r_ly <= '0;
      r_ty <= '0;
    end else if (w_load) begin
      if (w_lastPx) begin
        r_px <= '0;
        if (w_lastLy) begin
          r_ly <= '0;
          r_ty <= w_lastTy ? '0 : r_ty + TYW'(1);
        end else begin
          r_ly <= r_ly + LYW'(1);
        end
      end else begin
        r_px <= r_px + PXW'(1);
      end
    end
  end

  // Registered output stage: load a new pixel when empty or being accepted,
  // otherwise hold; drop valid once the held pixel is taken with nothing new.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pixelOut   <= '0;
      r_pixelValid <= 1'b0;
      r_pixelSol   <= 1'b0;
      r_pixelEol   <= 1'b0;
      r_pixelSof   <= 1'b0;
      r_pixelEof   <= 1'b0;
    end else if (w_load) begin
      r_pixelOut   <= w_pixBit ? FG_COLOR : BG_COLOR;
      r_pixelValid <= 1'b1;
      r_pixelSol   <= (r_px == '0);
      r_pixelEol   <= w_lastPx;
      r_pixelSof   <= (r_ty == '0) && (r_ly == '0) && (r_px == '0);
      r_pixelEof   <= w_lastTy && w_lastLy && w_lastPx;
    end else if (io_rw.pixel_ready) begin
      r_pixelValid <= 1'b0;
      r_pixelSol   <= 1'b0;
      r_pixelEol   <= 1'b0;
      r_pixelSof   <= 1'b0;
      r_pixelEof   <= 1'b0;
    end
  end

  assign io_rw.pixel_out   = r_pixelOut;
  assign io_rw.pixel_valid = r_pixelValid;
  assign io_rw.pixel_sol   = r_pixelSol;
  assign io_rw.pixel_eol   = r_pixelEol;
  assign io_rw.pixel_sof   = r_pixelSof;
  assign io_rw.pixel_eof   = r_pixelEof;

endmodule

// File: tb/tb_ascii_raster_writer.sv
// Testbench for ascii_raster_writer on a 16x16 frame of 8x8 tiles.
// Rows of tiles are described in a vector table; a reference model pushes
// every expected pixel into a queue and a monitor pops and compares on each
// accepted pixel. Hand-written sequences cover a reset in the middle of a row.
module tb_ascii_raster_writer;

  localparam int W      = 16;
  localparam int H      = 16;
  localparam int TW     = 8;
  localparam int TH     = 8;
  localparam int DW     = 24;
  localparam int ROWPIX = W * TH;
  localparam logic [DW-1:0] FG = 24'hFFFFFF;
  localparam logic [DW-1:0] BG = 24'h000000;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sol;
    logic          eol;
    logic          sof;
    logic          eof;
  } pix_t;

  typedef struct {
    logic [63:0] tile0;
    logic [63:0] tile1;
    bit          stall;
    int          expFg;
  } rowVec_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   totalAcc = 0;
  int   totalFg = 0;
  bit   stallMode = 1'b0;
  int   tbTy = 0;
  pix_t expQ[$];
  pix_t cur;
  pix_t prevPix;
  bit   prevStall = 1'b0;

  rowVec_t vecs[4];

  always #5 clk = ~clk;

  ascii_raster_writer_if #(.TILE_WIDTH(TW), .TILE_HEIGHT(TH), .DATA_WIDTH(DW)) bus ();

  ascii_raster_writer #(
    .WIDTH(W), .HEIGHT(H), .TILE_WIDTH(TW), .TILE_HEIGHT(TH),
    .COLORS(3), .COLOR_DEPTH(8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .io_rw  (bus)
  );

  // Compare one value against its expectation and record the outcome.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected pixel stream for one tile row.
  task automatic pushRow(input logic [63:0] t0, input logic [63:0] t1, input int ty);
    pix_t p;
    logic [63:0] t;
    for (int ly = 0; ly < TH; ly++) begin
      for (int px = 0; px < W; px++) begin
        t = (px < TW) ? t0 : t1;
        p.data = t[(px % TW) * TH + ly] ? FG : BG;
        p.sol  = (px == 0);
        p.eol  = (px == W - 1);
        p.sof  = (ty == 0) && (ly == 0) && (px == 0);
        p.eof  = (ty == 1) && (ly == TH - 1) && (px == W - 1);
        expQ.push_back(p);
      end
    end
  endtask

  // Present one tile and hold it until the writer takes it.
  task automatic sendTile(input logic [63:0] t);
    bit got = 1'b0;
    bus.tile_in    = t;
    bus.tile_valid = 1'b1;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (bus.tile_ready) got = 1'b1;
    end
    checkOutput("tileAccept", {63'b0, got}, 64'd1);
    @(posedge clk);
    #1;
    bus.tile_valid = 1'b0;
  endtask

  // Drive one full row of tiles and follow its drain to completion.
  task automatic applyStimulus(input rowVec_t v, input int ty);
    int base;
    int fgBase;
    int span;
    bit done;
    stallMode = v.stall;
    base   = totalAcc;
    fgBase = totalFg;
    pushRow(v.tile0, v.tile1, ty);
    sendTile(v.tile0);
    sendTile(v.tile1);
    @(negedge clk);
    checkOutput("drainLatencyValid", {63'b0, bus.pixel_valid}, 64'd0);
`ifdef ASCII_RASTER_DBUF_EN
    checkOutput("drainTileReady", {63'b0, bus.tile_ready}, 64'd1);
`else
    checkOutput("drainTileReady", {63'b0, bus.tile_ready}, 64'd0);
`endif
    @(negedge clk);
    checkOutput("firstValid", {63'b0, bus.pixel_valid}, 64'd1);
    #1;
    span = 1;
    done = (totalAcc - base >= ROWPIX);
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      #1;
      span++;
      done = (totalAcc - base >= ROWPIX);
    end
    checkOutput("rowDone", {63'b0, done}, 64'd1);
    checkOutput("rowAccepted", 64'(totalAcc - base), 64'(ROWPIX));
    checkOutput("fgCount", 64'(totalFg - fgBase), 64'(v.expFg));
    if (!v.stall) checkOutput("rowSpan", 64'(span), 64'(ROWPIX));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("validDrop", {63'b0, bus.pixel_valid}, 64'd0);
    checkOutput("readyAfterRow", {63'b0, bus.tile_ready}, 64'd1);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    stallMode = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: always high, or random 1/0 when stalling is requested.
  always @(posedge clk) begin
    #1;
    bus.pixel_ready = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: hold-stability under stall and scoreboard compare on acceptance.
  always @(negedge clk) begin
    if (!rstN) begin
      prevStall = 1'b0;
    end else begin
      cur = {bus.pixel_out, bus.pixel_sol, bus.pixel_eol, bus.pixel_sof, bus.pixel_eof};
      if (prevStall) begin
        checkOutput("stallHold", {35'b0, bus.pixel_valid, cur}, {35'b0, 1'b1, prevPix});
      end
      if (bus.pixel_valid && bus.pixel_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPixel", 64'd1, 64'd0);
        end else begin
          checkOutput("pixel", {36'b0, cur}, {36'b0, expQ.pop_front()});
        end
        totalAcc++;
        if (bus.pixel_out == FG) totalFg++;
      end
      prevStall = bus.pixel_valid && !bus.pixel_ready;
      prevPix   = cur;
    end
  end

  initial begin
    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 64};
    vecs[1] = '{64'h0000_0000_2000_0000, 64'h0, 1'b0, 1};
    vecs[2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64};
    vecs[3] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64};

    bus.tile_valid = 1'b0;
    bus.tile_in    = '0;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetValid", {63'b0, bus.pixel_valid}, 64'd0);
    checkOutput("resetData", 64'(bus.pixel_out), 64'd0);
    checkOutput("resetFlags", {60'b0, bus.pixel_sol, bus.pixel_eol, bus.pixel_sof, bus.pixel_eof}, 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("resetTileReady", {63'b0, bus.tile_ready}, 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      $display("[TB] row vector %0d (ty=%0d)", i, tbTy);
      applyStimulus(vecs[i], tbTy);
      tbTy = (tbTy + 1) % 2;
    end

    // Reset in the middle of a row: stream aborts, next row restarts the frame.
    begin
      int base;
      bit reached = 1'b0;
      $display("[TB] reset mid-drain");
      base = totalAcc;
      pushRow(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, tbTy);
      sendTile(64'hFFFF_FFFF_FFFF_FFFF);
      sendTile(64'hFFFF_FFFF_FFFF_FFFF);
      for (int n = 0; n < 2000 && !reached; n++) begin
        @(negedge clk);
        #1;
        reached = (totalAcc - base >= 40);
      end
      checkOutput("reach40", {63'b0, reached}, 64'd1);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("asyncRstValid", {63'b0, bus.pixel_valid}, 64'd0);
      checkOutput("asyncRstData", 64'(bus.pixel_out), 64'd0);
      checkOutput("asyncRstFlags", {60'b0, bus.pixel_sol, bus.pixel_eol, bus.pixel_sof, bus.pixel_eof}, 64'd0);
      expQ.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("postRstTileReady", {63'b0, bus.tile_ready}, 64'd1);
      checkOutput("postRstValid", {63'b0, bus.pixel_valid}, 64'd0);
      @(posedge clk);
      #1;
      tbTy = 0;
    end

    applyStimulus(vecs[3], tbTy);
    tbTy = (tbTy + 1) % 2;
    applyStimulus(vecs[0], tbTy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
